// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller:
// access sizes, FSM states, byte-lane enables and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] BHW_WORD = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR
    } state_t;

    // Big-endian lanes: bit 3 enables bits 31:24, which is byte offset 0.
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LANE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;

    // Size 2'b11 falls into the word rule.
    function automatic logic isMisaligned(input logic [1:0] bhw, input logic [1:0] offset);
        case (bhw)
            BHW_BYTE: return 1'b0;
            BHW_HALF: return offset[0];
            default:  return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory req/ack bus: the controller is master, the memory is slave.
// ack is a single-cycle completion strobe; rdata is only meaningful with ack.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store replication, byte enables, load extract and extend.
// Latency: combinational.
// Backpressure: none; operands are held by the controller for the whole access.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  bhw,
    input  logic [1:0]  offset,
    input  logic        isWrite,
    input  logic        extendSign,
    input  logic [31:0] storeData,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] loadExt
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = rdata[31:24];
        case (offset)
            2'd1:    byteSel = rdata[23:16];
            2'd2:    byteSel = rdata[15:8];
            2'd3:    byteSel = rdata[7:0];
            default: byteSel = rdata[31:24];
        endcase
        halfSel = offset[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        wdata   = storeData;
        be      = BE_ALL;
        loadExt = rdata;
        case (bhw)
            BHW_BYTE: begin
                wdata   = {4{storeData[7:0]}};
                be      = BE_LANE0 >> offset;
                loadExt = {{24{extendSign & byteSel[7]}}, byteSel};
            end
            BHW_HALF: begin
                wdata   = {2{storeData[15:0]}};
                be      = offset[1] ? BE_HALF_LO : BE_HALF_HI;
                loadExt = {{16{extendSign & halfSel[15]}}, halfSel};
            end
            default: ;
        endcase
        // Loads read the whole word; the lane is picked out on the way back.
        if (!isWrite) begin
            be = BE_ALL;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: one req/ack data-memory transaction per instruction.
// Latency: bus_req the cycle after start; load_valid the cycle after bus_ack.
// Backpressure: stall holds the pipeline until DONE/ERR; no ack -> timeout abort.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        bhw,
    input  logic              extend_sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    dmem_access_ctrl_if.master bus,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              addr_err,
    output logic              bus_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, stateNxt;
    logic [CNT_W-1:0] reqCnt;
    logic [1:0]       accBhw;
    logic [1:0]       accOffset;
    logic             accSign;

    logic             start;
    logic             misaligned;
    logic             timeoutHit;
    logic [1:0]       alignBhw;
    logic [1:0]       alignOffset;
    logic [31:0]      alignWdata;
    logic [3:0]       alignBe;
    logic [31:0]      loadExt;

    assign start      = mem_read | mem_write;
    assign misaligned = isMisaligned(bhw, addr[1:0]);
    assign timeoutHit = (reqCnt == CNT_LAST);

    // Live fields set up the bus in IDLE; latched copies steer the returning data.
    assign alignBhw    = (state == ST_IDLE) ? bhw       : accBhw;
    assign alignOffset = (state == ST_IDLE) ? addr[1:0] : accOffset;

    dmem_lane_align u_lane_align (
        .bhw        (alignBhw),
        .offset     (alignOffset),
        .isWrite    (mem_write),
        .extendSign (accSign),
        .storeData  (store_data),
        .rdata      (bus.rdata),
        .wdata      (alignWdata),
        .be         (alignBe),
        .loadExt    (loadExt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        stall    = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = start & rst;
                if (start) begin
                    stateNxt = misaligned ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus.ack) begin
                    stateNxt = ST_DONE;
                end else if (timeoutHit) begin
                    stateNxt = ST_ERR;
                end
            end
            ST_DONE: stateNxt = ST_IDLE;
            ST_ERR:  stateNxt = ST_IDLE;
            default: stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.req     <= 1'b0;
            bus.we      <= 1'b0;
            bus.addr    <= '0;
            bus.be      <= '0;
            bus.wdata   <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            addr_err    <= 1'b0;
            bus_timeout <= 1'b0;
            reqCnt      <= '0;
            accBhw      <= BHW_WORD;
            accOffset   <= 2'b00;
            accSign     <= 1'b0;
        end else begin
            load_valid  <= 1'b0;
            addr_err    <= 1'b0;
            bus_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    reqCnt <= '0;
                    if (start) begin
                        if (misaligned) begin
                            addr_err <= 1'b1;
                        end else begin
                            bus.req   <= 1'b1;
                            bus.we    <= mem_write;
                            bus.addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus.be    <= alignBe;
                            bus.wdata <= mem_write ? alignWdata : 32'h0;
                            accBhw    <= bhw;
                            accOffset <= addr[1:0];
                            accSign   <= extend_sign;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack arriving on the expiry cycle still completes the access.
                    if (bus.ack) begin
                        bus.req <= 1'b0;
                        if (!bus.we) begin
                            load_data  <= loadExt;
                            load_valid <= 1'b1;
                        end
                    end else if (timeoutHit) begin
                        bus.req     <= 1'b0;
                        bus_timeout <= 1'b1;
                    end else begin
                        reqCnt <= reqCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized accesses
// checked against an arithmetic model of lane steering and handshake timing.
module tb_dmem_access_ctrl;

    localparam int TO = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write, extend_sign;
    logic [1:0]    bhw;
    logic [AW-1:0] addr;
    logic [31:0]   store_data;
    logic          stall, load_valid, addr_err, bus_timeout;
    logic [31:0]   load_data;

    int checks = 0;
    int failures = 0;

    int nStall, nReq, nValid, nErr, nTo, ackCycle, validCycle;
    logic [31:0] obsAddr, obsWdata, obsLoad;
    logic [3:0]  obsBe;
    logic        obsWe;
    logic [31:0] lastLoad;

    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(AW)) bus ();

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .bhw         (bhw),
        .extend_sign (extend_sign),
        .addr        (addr),
        .store_data  (store_data),
        .bus         (bus),
        .stall       (stall),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .addr_err    (addr_err),
        .bus_timeout (bus_timeout)
    );

    // ---------------- reference model ----------------
    function automatic bit mdlMisaligned(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'b10) return 1'b0;
        if (sz == 2'b01) return (int'(off) % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [3:0] mdlBe(input logic [1:0] sz, input logic [1:0] off, input bit wr);
        if (!wr) return 4'hF;
        if (sz == 2'b10) return 4'(1 << (3 - int'(off)));
        if (sz == 2'b01) return (int'(off) >= 2) ? 4'h3 : 4'hC;
        return 4'hF;
    endfunction

    function automatic logic [31:0] mdlWdata(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'b10) return (sd & 32'hFF) * 32'h01010101;
        if (sz == 2'b01) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] mdlLoad(input logic [1:0] sz, input bit sgn,
                                            input logic [1:0] off, input logic [31:0] rd);
        int unsigned v;
        int unsigned w;
        if (sz == 2'b10) begin
            v = (rd >> (8 * (3 - int'(off)))) & 32'hFF;
            w = 8;
        end else if (sz == 2'b01) begin
            v = (rd >> ((int'(off) >= 2) ? 0 : 16)) & 32'hFFFF;
            w = 16;
        end else begin
            return rd;
        end
        if (sgn && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
        return v;
    endfunction

    // ---------------- transaction driver ----------------
    // ackAt: index of the REQ cycle in which the memory acks; -1 never acks.
    task automatic runTxn(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int ackAt);
        int  reqIdx;
        bit  left;
        bit  clearNext;
        nStall = 0; nReq = 0; nValid = 0; nErr = 0; nTo = 0;
        ackCycle = -1; validCycle = -1; reqIdx = 0; left = 0; clearNext = 0;
        obsAddr = 0; obsWdata = 0; obsBe = 0; obsWe = 0; obsLoad = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; bhw = sz; extend_sign = sgn;
        addr = a; store_data = sd;
        for (int c = 0; c < 16; c++) begin
            if (clearNext) begin
                mem_read = 0; mem_write = 0; clearNext = 0;
            end
            #1;
            if (stall) nStall++;
            if (bus.req) begin
                nReq++;
                obsAddr = bus.addr; obsBe = bus.be; obsWdata = bus.wdata; obsWe = bus.we;
                if (reqIdx == ackAt) begin
                    bus.ack = 1'b1; bus.rdata = rdat; ackCycle = c;
                end
                reqIdx++;
            end
            if (load_valid) begin
                nValid++; validCycle = c; obsLoad = load_data;
            end
            if (addr_err) nErr++;
            if (bus_timeout) nTo++;
            if (!left && c > 0 && !stall) begin
                left = 1; clearNext = 1;
            end
            @(negedge clk);
            bus.ack = 1'b0;
        end
        mem_read = 0; mem_write = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b0;
        mem_read = 0; mem_write = 0; bhw = 0; extend_sign = 0; addr = 0; store_data = 0;
        bus.ack = 0; bus.rdata = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req, bus.we, bus.addr, bus.be, bus.wdata, load_data, load_valid,
             addr_err, bus_timeout, stall} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b be=%h addr=%h ld=%h stall=%b expected all zero",
                     bus.req, bus.be, bus.addr, load_data, stall);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({bus.req, stall, load_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: req=%b stall=%b valid=%b expected 000", bus.req, stall, load_valid);
        end
        lastLoad = 0;
    endtask

    task automatic test_word_store;
        runTxn(0, 1, 2'b00, 0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
        checks++; if (obsAddr !== 32'h100) begin failures++; $display("FAIL ws_addr: got %h want 00000100", obsAddr); end
        checks++; if (obsBe !== 4'hF) begin failures++; $display("FAIL ws_be: got %b want 1111", obsBe); end
        checks++; if (obsWdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ws_wdata: got %h want deadbeef", obsWdata); end
        checks++; if (obsWe !== 1'b1) begin failures++; $display("FAIL ws_we: got %b want 1", obsWe); end
        checks++; if (nStall !== 4) begin failures++; $display("FAIL ws_stall: got %0d cycles want 4", nStall); end
        checks++; if (nReq !== 3) begin failures++; $display("FAIL ws_req: got %0d cycles want 3", nReq); end
        checks++; if (nValid !== 0) begin failures++; $display("FAIL ws_valid: got %0d pulses want 0", nValid); end
    endtask

    task automatic test_byte_load;
        runTxn(1, 0, 2'b10, 1, 32'h203, 32'h0, 32'h123456F0, 1);
        checks++; if (obsBe !== 4'hF) begin failures++; $display("FAIL bl_be: got %b want 1111", obsBe); end
        checks++; if (obsAddr !== 32'h200) begin failures++; $display("FAIL bl_addr: got %h want 00000200", obsAddr); end
        checks++; if (obsLoad !== 32'hFFFFFFF0) begin failures++; $display("FAIL bl_sext: got %h want fffffff0", obsLoad); end
        checks++; if (nValid !== 1 || validCycle !== ackCycle + 1) begin
            failures++; $display("FAIL bl_latency: pulses=%0d at %0d want 1 at %0d", nValid, validCycle, ackCycle + 1);
        end
        runTxn(1, 0, 2'b10, 0, 32'h203, 32'h0, 32'h123456F0, 0);
        checks++; if (obsLoad !== 32'h000000F0) begin failures++; $display("FAIL bl_zext: got %h want 000000f0", obsLoad); end
        lastLoad = 32'h000000F0;
    endtask

    task automatic test_halfword;
        runTxn(0, 1, 2'b01, 0, 32'h42, 32'h0000ABCD, 32'h0, 0);
        checks++; if (obsAddr !== 32'h40) begin failures++; $display("FAIL hs_addr: got %h want 00000040", obsAddr); end
        checks++; if (obsBe !== 4'b0011) begin failures++; $display("FAIL hs_be: got %b want 0011", obsBe); end
        checks++; if (obsWdata !== 32'hABCDABCD) begin failures++; $display("FAIL hs_wdata: got %h want abcdabcd", obsWdata); end
        checks++; if (load_data !== lastLoad) begin failures++; $display("FAIL hs_hold: load_data %h want %h", load_data, lastLoad); end
        runTxn(1, 0, 2'b01, 1, 32'h40, 32'h0, 32'h80011234, 0);
        checks++; if (obsLoad !== 32'hFFFF8001) begin failures++; $display("FAIL hl_sext: got %h want ffff8001", obsLoad); end
        lastLoad = 32'hFFFF8001;
    endtask

    task automatic test_misaligned;
        runTxn(1, 0, 2'b00, 0, 32'h101, 32'h0, 32'h55AA55AA, 0);
        checks++; if (nReq !== 0) begin failures++; $display("FAIL mis_req: got %0d req cycles want 0", nReq); end
        checks++; if (nErr !== 1) begin failures++; $display("FAIL mis_err: got %0d pulses want 1", nErr); end
        checks++; if (nStall !== 1) begin failures++; $display("FAIL mis_stall: got %0d cycles want 1", nStall); end
        checks++; if (load_data !== lastLoad) begin failures++; $display("FAIL mis_hold: load_data %h want %h", load_data, lastLoad); end
    endtask

    task automatic test_timeout;
        runTxn(1, 0, 2'b00, 0, 32'h300, 32'h0, 32'h0, -1);
        checks++; if (nReq !== TO) begin failures++; $display("FAIL to_req: got %0d cycles want %0d", nReq, TO); end
        checks++; if (nTo !== 1) begin failures++; $display("FAIL to_pulse: got %0d pulses want 1", nTo); end
        checks++; if (nStall !== TO + 1) begin failures++; $display("FAIL to_stall: got %0d want %0d", nStall, TO + 1); end
        checks++; if (nValid !== 0) begin failures++; $display("FAIL to_valid: got %0d want 0", nValid); end
        runTxn(1, 0, 2'b00, 0, 32'h304, 32'h0, 32'h13579BDF, 0);
        checks++; if (nStall !== 2) begin failures++; $display("FAIL after_to_stall: got %0d want 2", nStall); end
        checks++; if (obsLoad !== 32'h13579BDF || nValid !== 1) begin
            failures++; $display("FAIL after_to_load: got %h x%0d want 13579bdf x1", obsLoad, nValid);
        end
        lastLoad = 32'h13579BDF;
    endtask

    task automatic test_reset_mid;
        bit sawReq;
        @(negedge clk);
        mem_read = 1; mem_write = 0; bhw = 2'b00; extend_sign = 0; addr = 32'h500;
        @(negedge clk); @(negedge clk);
        sawReq = bus.req;
        checks++; if (sawReq !== 1'b1) begin failures++; $display("FAIL rm_inreq: req=%b want 1", sawReq); end
        rst = 1'b0;
        #1;
        checks++; if ({bus.req, stall} !== 2'b00) begin
            failures++; $display("FAIL rm_async: req=%b stall=%b want 00", bus.req, stall);
        end
        mem_read = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); bus.ack = 1'b1; bus.rdata = $urandom;
        @(negedge clk); bus.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({bus.req, stall, load_valid} !== 3'b000) begin
                failures++; $display("FAIL rm_late_ack: req=%b stall=%b valid=%b want 000", bus.req, stall, load_valid);
            end
            @(negedge clk);
        end
        checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL rm_ldata: got %h want 0", load_data); end
        lastLoad = 0;
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            logic [1:0]  sz, off;
            logic [31:0] a, sd, rd;
            bit rdReq, wrReq, sgn, isWr;
            int kind, ackAt;
            logic [31:0] expLd;
            sz    = 2'($urandom_range(0, 3));
            off   = 2'($urandom_range(0, 3));
            a     = ($urandom & 32'hFFFF_FFFC) | 32'(off);
            sd    = $urandom;
            rd    = $urandom;
            sgn   = 1'($urandom_range(0, 1));
            kind  = $urandom_range(0, 2);
            rdReq = (kind != 1);
            wrReq = (kind != 0);
            isWr  = wrReq;
            ackAt = $urandom_range(0, 5);
            runTxn(rdReq, wrReq, sz, sgn, a, sd, rd, ackAt);
            if (mdlMisaligned(sz, off)) begin
                checks++;
                if (nReq !== 0 || nErr !== 1 || nStall !== 1) begin
                    failures++; $display("FAIL rnd_mis[%0d]: req=%0d err=%0d stall=%0d want 0/1/1", n, nReq, nErr, nStall);
                end
            end else if (ackAt < TO) begin
                checks++;
                if (nReq !== ackAt + 1 || nStall !== ackAt + 2) begin
                    failures++; $display("FAIL rnd_timing[%0d]: req=%0d stall=%0d want %0d/%0d", n, nReq, nStall, ackAt + 1, ackAt + 2);
                end
                checks++;
                if (obsAddr !== (a & 32'hFFFF_FFFC) || obsBe !== mdlBe(sz, off, isWr) || obsWe !== isWr) begin
                    failures++; $display("FAIL rnd_bus[%0d]: addr=%h be=%b we=%b want %h/%b/%b", n, obsAddr, obsBe, obsWe,
                                         a & 32'hFFFF_FFFC, mdlBe(sz, off, isWr), isWr);
                end
                if (isWr) begin
                    checks++;
                    if (obsWdata !== mdlWdata(sz, sd) || nValid !== 0) begin
                        failures++; $display("FAIL rnd_store[%0d]: wdata=%h valid=%0d want %h/0", n, obsWdata, nValid, mdlWdata(sz, sd));
                    end
                end else begin
                    expLd = mdlLoad(sz, sgn, off, rd);
                    checks++;
                    if (obsLoad !== expLd || nValid !== 1 || validCycle !== ackCycle + 1) begin
                        failures++; $display("FAIL rnd_load[%0d]: data=%h valid=%0d at %0d want %h at %0d", n, obsLoad, nValid,
                                             validCycle, expLd, ackCycle + 1);
                    end
                    lastLoad = expLd;
                end
            end else begin
                checks++;
                if (nReq !== TO || nTo !== 1 || nValid !== 0) begin
                    failures++; $display("FAIL rnd_timeout[%0d]: req=%0d to=%0d valid=%0d want %0d/1/0", n, nReq, nTo, nValid, TO);
                end
            end
            checks++;
            if (load_data !== lastLoad) begin
                failures++; $display("FAIL rnd_hold[%0d]: load_data %h want %h", n, load_data, lastLoad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_halfword();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM latch outputs.
- Takes the registered memory-control fields, runs one data-memory transaction per instruction over a req/ack bus, and stalls the pipeline until the transaction completes.
- Handles big-endian byte-lane alignment for byte, halfword and word accesses, and sign or zero extension of load data.
- Feeds load data and the error flags toward MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 16: REQ-state cycles without bus_ack before the transaction is aborted; minimum 1.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request, from EX/MEM.
- mem_write  in  1  store request, from EX/MEM.
- bhw  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- extend_sign  in  1  for loads: 1 sign-extends, 0 zero-extends.
- addr  in  ADDR_W  byte address (ALU result).
- store_data  in  32  store operand (ReadData2); low-order bits are used for sub-word stores.
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}), registered.
- bus_be  out  4  byte enables; be[3] = bits 31:24 = byte offset 0; registered.
- bus_wdata  out  32  lane-replicated store data, registered.
- bus_rdata  in  32  read data, sampled on bus_ack.
- bus_ack  in  1  single-cycle completion strobe.
- stall  out  1  freezes IF/ID/EX and the EX/MEM latch.
- load_data  out  32  extended load result, registered.
- load_valid  out  1  one-cycle pulse: load_data is valid.
- addr_err  out  1  one-cycle pulse: misaligned access.
- bus_timeout  out  1  one-cycle pulse: no ack within TIMEOUT_CYCLES.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all registered outputs 0, including bus_req, bus_we, bus_addr, bus_be, bus_wdata, load_data, load_valid, addr_err, bus_timeout and the timeout counter. stall is 0 in IDLE with no access pending. A reset asserted mid-transaction drops bus_req immediately and discards any pending ack.
- Start condition, start = mem_read | mem_write, evaluated in IDLE only. If both are high, the access is a write.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. No bus request is issued.
- States:
  - IDLE: stall = start.
    - start and aligned: load the bus registers, go to REQ.
    - start and misaligned: go to ERR with addr_err set.
    - otherwise: stay in IDLE.
  - REQ: bus_req=1, stall=1, timeout counter increments each cycle.
    - bus_ack: capture extended rdata into load_data, set load_valid if the access is a read, clear bus_req, go to DONE.
    - counter reaches TIMEOUT_CYCLES-1 with no ack: clear bus_req, set bus_timeout, go to ERR.
  - DONE: stall=0, so the instruction leaves the EX/MEM latch at this edge. No new start is accepted. Go to IDLE.
  - ERR: stall=0, the flag pulse is visible for this cycle. Go to IDLE.
- Latency: an aligned access asserts bus_req in the cycle after start. An ack in REQ cycle k gives load_valid in cycle k+1. Minimum stall is 2 cycles (IDLE plus one REQ cycle).
- Store alignment (a = addr[1:0]):
  - byte: wdata = {4{store_data[7:0]}}, be = 4'b1000 >> a.
  - halfword: wdata = {2{store_data[15:0]}}, be = a[1] ? 0011 : 1100.
  - word: wdata = store_data, be = 1111.
- Load extraction:
  - byte: rdata[31-8a -: 8].
  - halfword: a[1] ? rdata[15:0] : rdata[31:16].
  - Result is extended to 32 bits using extend_sign.
  - Loads drive be = 1111 on the bus; the lane is selected internally.
- bus_ack outside REQ is ignored. bus_ack in the same cycle as timeout expiry counts as an ack.
- load_data holds its value until the next completed load.

Decomposition:
- Package dmem_pkg:
  - BHW encodings: BHW_WORD=2'b00, BHW_HALF=2'b01, BHW_BYTE=2'b10.
  - State encoding: IDLE, REQ, DONE, ERR.
  - Byte-lane enable constants.
- Sub-module dmem_lane_align: combinational store replication, bus_be generation, and load extract/extend. Instantiated once.

Test Plan:
- Word store, addr=0x100, store_data=0xDEADBEEF, ack 3 cycles after req → bus_addr=0x100, be=1111, wdata=0xDEADBEEF; stall high 4 cycles; no load_valid.
- Byte load, addr=0x203, extend_sign=1, rdata=0x123456F0 → be=1111, load_data=0xFFFFFFF0, load_valid one cycle after ack. Repeat with extend_sign=0 → 0x000000F0.
- Halfword store, addr=0x42, store_data=0x0000ABCD → bus_addr=0x40, be=0011, wdata=0xABCDABCD. Halfword load, addr=0x40, rdata=0x8001xxxx, extend_sign=1 → load_data=0xFFFF8001.
- Misaligned word load, addr=0x101 → bus_req never asserted; addr_err pulses once; stall high exactly 1 cycle.
- TIMEOUT_CYCLES=4, no ack → bus_req high exactly 4 cycles; bus_timeout pulse; back to IDLE. A later access with ack succeeds normally.
- rst driven low during REQ → bus_req and stall drop asynchronously. After release with mem_read=mem_write=0: stays in IDLE, and a late bus_ack has no effect.
